// File: rtl/data_sram_resp.sv
// Data-side SRAM responder for the CPU data port: accepts one request at a time,
// inserts WAIT_CYCLES wait states, then pulses data_ok with read data or an address error.
module data_sram_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        addr_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_count;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wen;
    logic                  r_dataOk;
    logic                  r_addrErr;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [0:(2**DEPTH_LOG2)-1];

    logic                  w_accept;
    logic                  w_enterResp;
    logic [31:0]           w_addr;
    logic [3:0]            w_wen;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_outOfRange;
    logic                  w_misaligned;
    logic                  w_err;

    assign data_sram_addr_ok = (r_state == IDLE) & ~rst;
    assign w_accept          = data_sram_en & data_sram_addr_ok;
    assign busy              = (r_state != IDLE) | w_accept;
    assign data_sram_data_ok = r_dataOk;
    assign addr_err          = r_addrErr;
    assign data_sram_rdata   = r_rdata;

    // With zero wait states RESP is entered on the accept edge, so the live inputs must be decoded.
    assign w_addr       = (r_state == IDLE) ? data_sram_addr : r_addr;
    assign w_wen        = (r_state == IDLE) ? data_sram_wen  : r_wen;
    assign w_idx        = w_addr[DEPTH_LOG2+1:2];
    assign w_outOfRange = |w_addr[31:DEPTH_LOG2+2];
    assign w_err        = w_outOfRange | w_misaligned;
    assign w_enterResp  = (w_nextState == RESP);

    always_comb begin
        w_misaligned = 1'b0;
        if ((w_wen == 4'b0000) && (w_addr[1:0] != 2'b00)) begin
            w_misaligned = 1'b1;
        end
        if ((w_wen == 4'b1111) && (w_addr[1:0] != 2'b00)) begin
            w_misaligned = 1'b1;
        end
        if (((w_wen == 4'b0011) || (w_wen == 4'b1100)) && w_addr[0]) begin
            w_misaligned = 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_nextState = RESP;
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 4'd0;
            r_dataOk  <= 1'b0;
            r_addrErr <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_dataOk  <= w_enterResp;
            r_addrErr <= w_enterResp & w_err;
            if (w_enterResp && (w_wen == 4'b0000)) begin
                r_rdata <= w_err ? 32'h0 : r_mem[w_idx];
            end
            if (w_accept) begin
                r_count <= LP_WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Request fields are captured only on accept so they stay stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= data_sram_addr;
            r_wen   <= data_sram_wen;
            r_wdata <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state == RESP) && (r_wen != 4'b0000) && !r_addrErr) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wen[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10; log2 of word count; the array holds 1024 x 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1; wait-state cycles between request accept and response, legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port data_sram_en  input  1  request valid from the CPU data port.
REQ-006 SHALL have port data_sram_wen  input  4  byte write enables, bit i = byte i; 4'b0000 means read.
REQ-007 SHALL have port data_sram_addr  input  32  byte address.
REQ-008 SHALL have port data_sram_wdata  input  32  store data, already byte-lane aligned.
REQ-009 SHALL have port data_sram_addr_ok  output  1  request accepted this cycle.
REQ-010 SHALL have port data_sram_data_ok  output  1  one-cycle response pulse.
REQ-011 SHALL have port data_sram_rdata  output  32  read data; valid while data_ok=1, then held.
REQ-012 SHALL have port addr_err  output  1  pulses with data_ok when the access was out of range or misaligned.
REQ-013 SHALL have port busy  output  1  high from accept until the cycle after the data_ok cycle; drives the pipeline stall.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL assert addr_ok combinationally only in IDLE; accept = data_sram_en & addr_ok.
REQ-016 On accept SHALL latch addr, wen and wdata, then:
- WAIT_CYCLES=0: go to RESP;
- otherwise: go to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-017 In WAIT SHALL decrement the counter each cycle and go to RESP in the cycle it reads 0.
REQ-018 The response latency SHALL be exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 In RESP SHALL set data_ok=1 for exactly one cycle and return to IDLE on the next edge.
REQ-020 A new request SHALL NOT be accepted in the RESP cycle, so back-to-back accepts are WAIT_CYCLES+2 cycles apart.
REQ-021 Inputs SHALL be ignored outside IDLE; latched values SHALL NOT change mid-transaction.
REQ-022 Word index SHALL be addr[DEPTH_LOG2+1:2].
REQ-023 Out of range (any of addr[31:DEPTH_LOG2+2] nonzero): read returns 32'h0, write is suppressed, addr_err=1.
REQ-024 Misaligned (SHALL flag addr_err=1 and suppress any write): read with addr[1:0]!=0; wen=4'b1111 with addr[1:0]!=0; wen=4'b0011 or 4'b1100 with addr[0]=1.
REQ-025 Legal single-byte enables (4'b0001, 4'b0010, 4'b0100, 4'b1000) SHALL be accepted at any addr[1:0].
REQ-026 A legal write SHALL update only the enabled bytes, on the edge that ends RESP.
REQ-027 On a write, data_sram_rdata SHALL keep its previous value.
REQ-028 On a legal read, data_sram_rdata SHALL be the full word registered at RESP entry; the CPU performs byte/half extraction.
REQ-029 A read immediately after a write to the same word SHALL return the post-write value.
REQ-030 busy SHALL equal (state != IDLE) | accept.

Reset
REQ-031 On rst=1 at an edge SHALL go to IDLE and clear the counter, data_ok, addr_err and data_sram_rdata to 32'h0.
REQ-032 rst SHALL take priority over every other event.
REQ-033 Array contents SHALL NOT be reset.
REQ-034 A pending write interrupted by reset SHALL be dropped with no array change and no data_ok.
REQ-035 When rst is asserted in a cycle, addr_ok SHALL be 0 in that cycle.

Verification
REQ-036 Read after reset (WAIT_CYCLES=1): write 32'hDEADBEEF to 0x10, then read 0x10 -> data_ok exactly 2 cycles after the read accept, rdata=32'hDEADBEEF, addr_err=0.
REQ-037 Byte merge: word 0x20 = 32'h11223344, write wen=4'b0100 wdata=32'h00AA0000 -> read 0x20 returns 32'h11AA3344.
REQ-038 Errors: read 0x00001002 -> addr_err=1; write wen=4'b1111 to 0x00010000 -> addr_err=1; a subsequent read of word 0 is unchanged.
REQ-039 Back-to-back (WAIT_CYCLES=0): en held high with 3 reads -> accepts spaced exactly 2 cycles apart, each data_ok 1 cycle after its accept, busy low only between transactions.
REQ-040 Reset mid-write: accept write 32'h55555555 to 0x40, assert rst in the WAIT cycle -> no data_ok; a later read of 0x40 returns the old value; rdata=0 right after reset.
